serial_link_top: RTL and testbench
==================================

// Module: serial_link_top
// PURPOSE
//   Parametrised full-duplex serial link endpoint. Replaces the fixed single-lane
//   i_rx_0/o_tx_0 top-level interface.
//   - TX side: accepts 2*WIDTH_BYTE-bit words over valid/ready into a WORDS-deep FIFO,
//     then serialises them as framed bits on o_tx_0.
//   - RX side: deserialises frames from i_rx_0 into o_a.
//   Sits between the core datapath and the device pins.
// PARAMETERS
//   WIDTH_BYTE    8   byte width; payload W = 2*WIDTH_BYTE bits
//   WORDS         8   TX FIFO depth in words; power of 2, >= 2
//   CLKS_PER_BIT  16  clk cycles per serial bit; even, >= 4
// PORTS
//   clk          in   1    single clock; all logic on rising edge
//   rst          in   1    asynchronous, active-low reset
//   i_a          in   W    TX payload word
//   i_a_valid    in   1    TX word valid
//   o_a_ready    out  1    FIFO can accept; transfer = i_a_valid & o_a_ready at clk edge
//   o_tx_0       out  1    serial TX line, idle high
//   o_tx_busy    out  1    TX FSM not in IDLE
//   o_level      out  CW   FIFO occupancy, CW = $clog2(WORDS+1)
//   i_rx_0       in   1    serial RX line, asynchronous to clk, idle high
//   o_a          out  W    last good RX word
//   o_a_valid    out  1    1-cycle pulse: o_a updated
//   o_frame_err  out  1    1-cycle pulse: bad stop bit (or parity, see CONFIGURATION)
// BEHAVIOUR
//   Reset (rst=0, immediate): o_tx_0=1, o_tx_busy=0, o_level=0, o_a_ready=1, o_a=0,
//     o_a_valid=0, o_frame_err=0. Both FSMs -> IDLE; FIFO emptied; in-flight frame
//     aborted (line returns high at once, no stop bit).
//   Frame format: start(0), W data bits LSB-first, [parity], stop(1).
//     Each bit lasts exactly CLKS_PER_BIT cycles.
//   FIFO
//     - o_a_ready = (o_level < WORDS).
//     - Push and pop on the same edge: o_level unchanged.
//     - Pointers wrap modulo WORDS.
//     - Push is never accepted while full, including on the pop edge; freed space is
//       visible the next cycle.
//   TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP
//     - IDLE: if FIFO non-empty, pop into shift register, go to START.
//     - Latency: word accepted into an empty FIFO with FSM idle at edge N
//       -> popped at edge N+1 -> o_tx_0 falls at edge N+2.
//     - DATA: shifts out W bits.
//     - STOP end: FIFO non-empty -> straight to START (back-to-back, no idle gap);
//       otherwise -> IDLE.
//   RX path
//     - i_rx_0 passes through a 2-flop synchroniser before use.
//     - IDLE: synchronised 0 -> START.
//     - START: count CLKS_PER_BIT/2, resample.
//       - 1 -> false start, back to IDLE.
//       - 0 -> DATA.
//     - DATA: samples every CLKS_PER_BIT (bit centre), W bits into an LSB-first shift reg.
//     - STOP: sample at bit centre.
//       - 1 -> o_a <= shift reg, o_a_valid pulses next cycle; FSM -> IDLE.
//       - 0 -> o_frame_err pulse, o_a held; wait for line high, then IDLE.
//     - TX and RX are fully independent and may run simultaneously.
// CONFIGURATION
//   SERIAL_PARITY_EN defined
//     - TX inserts an even-parity bit (XOR of data) between data and stop.
//     - RX checks it; mismatch -> o_frame_err pulse, no o_a_valid, o_a held.
//     - Frame = W+3 bits.
//   SERIAL_PARITY_EN undefined: no parity bit; frame = W+2 bits.
// TESTING (WIDTH_BYTE=8, WORDS=8, CLKS_PER_BIT=16, o_tx_0 looped to i_rx_0)
//   1. Reset: assert rst=0 mid-DATA -> o_tx_0=1, o_level=0, o_tx_busy=0 immediately,
//      no o_a_valid.
//   2. Loopback: push 16'hA55A at edge N -> o_tx_0 low at N+2; exactly one o_a_valid
//      with o_a=16'hA55A; o_frame_err never pulses.
//   3. Back-to-back: hold i_a_valid with 10 distinct words -> 9 accepted before
//      o_a_ready falls, o_level=8; all 10 received in order, no idle between frames.
//   4. Framing error: drive a frame with stop=0 on i_rx_0 -> one o_frame_err pulse,
//      o_a unchanged, next good frame received.
//   5. Glitch: 3-cycle low pulse on i_rx_0 -> no o_a_valid, no o_frame_err,
//      RX back to IDLE.
//   6. SERIAL_PARITY_EN: send 16'h0001 with parity bit 0 -> o_frame_err pulse;
//      with parity 1 -> o_a_valid, o_a=16'h0001.

Source files
------------

// File: rtl/serial_link_top.sv
// Full-duplex serial link endpoint: FIFO-buffered TX serialiser and 2-flop-synchronised RX deserialiser.
// Define SERIAL_PARITY_EN to add an even-parity bit between the data and stop bits.
module serial_link_top #(
    parameter int WIDTH_BYTE   = 8,
    parameter int WORDS        = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [2*WIDTH_BYTE-1:0]      i_a,
    input  logic                         i_a_valid,
    output logic                         o_a_ready,
    output logic                         o_tx_0,
    output logic                         o_tx_busy,
    output logic [$clog2(WORDS+1)-1:0]   o_level,
    input  logic                         i_rx_0,
    output logic [2*WIDTH_BYTE-1:0]      o_a,
    output logic                         o_a_valid,
    output logic                         o_frame_err
);
    localparam int W    = 2 * WIDTH_BYTE;
    localparam int CW   = $clog2(WORDS + 1);
    localparam int AW   = $clog2(WORDS);
    localparam int CNTW = $clog2(CLKS_PER_BIT);
    localparam int BW   = $clog2(W);
    localparam logic [CNTW-1:0] BIT_LAST  = CNTW'(CLKS_PER_BIT - 1);
    localparam logic [CNTW-1:0] HALF_LAST = CNTW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0]   DATA_LAST = BW'(W - 1);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;

    // ---------------- TX FIFO ----------------
    logic [W-1:0]  mem_q [WORDS];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] level_q, level_d;
    logic          push, pop, fifo_empty;

    assign o_a_ready  = (level_q < CW'(WORDS));
    assign push       = i_a_valid && o_a_ready;
    assign fifo_empty = (level_q == '0);
    assign o_level    = level_q;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= i_a;
    end

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
        end
    end

    // ---------------- TX FSM ----------------
    tx_state_t       tx_state_q, tx_state_d;
    logic [CNTW-1:0] tx_cnt_q, tx_cnt_d;
    logic [BW-1:0]   tx_bit_q, tx_bit_d;
    logic [W-1:0]    tx_shift_q, tx_shift_d;
    logic            tx_line_q, tx_line_d;
    logic            tx_bit_end;
`ifdef SERIAL_PARITY_EN
    logic            tx_par_q, tx_par_d;
`endif

    assign tx_bit_end = (tx_cnt_q == BIT_LAST);
    assign o_tx_busy  = (tx_state_q != TX_IDLE);
    assign o_tx_0     = tx_line_q;

    // Line is registered from the current state, so it trails the FSM by one cycle.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_line_d  = 1'b1;
        pop        = 1'b0;
`ifdef SERIAL_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        case (tx_state_q)
            TX_IDLE: pop = !fifo_empty;
            TX_START: begin
                tx_line_d = 1'b0;
                tx_cnt_d  = tx_cnt_q + 1'b1;
                if (tx_bit_end) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                tx_line_d = tx_shift_q[0];
                tx_cnt_d  = tx_cnt_q + 1'b1;
                if (tx_bit_end) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = tx_shift_q >> 1;
                    tx_bit_d   = tx_bit_q + 1'b1;
`ifdef SERIAL_PARITY_EN
                    if (tx_bit_q == DATA_LAST) tx_state_d = TX_PARITY;
`else
                    if (tx_bit_q == DATA_LAST) tx_state_d = TX_STOP;
`endif
                end
            end
`ifdef SERIAL_PARITY_EN
            TX_PARITY: begin
                tx_line_d = tx_par_q;
                tx_cnt_d  = tx_cnt_q + 1'b1;
                if (tx_bit_end) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_STOP;
                end
            end
`endif
            TX_STOP: begin
                tx_cnt_d = tx_cnt_q + 1'b1;
                if (tx_bit_end) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_IDLE;
                    pop        = !fifo_empty;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        if (pop) begin
            tx_shift_d = mem_q[rd_ptr_q];
            tx_cnt_d   = '0;
            tx_state_d = TX_START;
`ifdef SERIAL_PARITY_EN
            tx_par_d   = ^mem_q[rd_ptr_q];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_line_q  <= 1'b1;
`ifdef SERIAL_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_line_q  <= tx_line_d;
`ifdef SERIAL_PARITY_EN
            tx_par_q   <= tx_par_d;
`endif
        end
    end

    // ---------------- RX path ----------------
    logic [1:0]      rx_sync_q;
    logic            rx_s, rx_par_good;
    rx_state_t       rx_state_q, rx_state_d;
    logic [CNTW-1:0] rx_cnt_q, rx_cnt_d;
    logic [BW-1:0]   rx_bit_q, rx_bit_d;
    logic [W-1:0]    rx_shift_q, rx_shift_d;
    logic [W-1:0]    a_q, a_d;
    logic            a_valid_q, a_valid_d, ferr_q, ferr_d;
`ifdef SERIAL_PARITY_EN
    logic            rx_par_ok_q, rx_par_ok_d;
    assign rx_par_good = rx_par_ok_q;
`else
    assign rx_par_good = 1'b1;
`endif

    assign rx_s        = rx_sync_q[1];
    assign o_a         = a_q;
    assign o_a_valid   = a_valid_q;
    assign o_frame_err = ferr_q;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        a_d        = a_q;
        a_valid_d  = 1'b0;
        ferr_d     = 1'b0;
`ifdef SERIAL_PARITY_EN
        rx_par_ok_d = rx_par_ok_q;
`endif
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (!rx_s) rx_state_d = RX_START;
            end
            RX_START: if (rx_cnt_q == HALF_LAST) begin
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt_q == BIT_LAST) begin
                rx_cnt_d   = '0;
                rx_shift_d = {rx_s, rx_shift_q[W-1:1]};
                rx_bit_d   = rx_bit_q + 1'b1;
`ifdef SERIAL_PARITY_EN
                if (rx_bit_q == DATA_LAST) rx_state_d = RX_PARITY;
`else
                if (rx_bit_q == DATA_LAST) rx_state_d = RX_STOP;
`endif
            end
`ifdef SERIAL_PARITY_EN
            RX_PARITY: if (rx_cnt_q == BIT_LAST) begin
                rx_cnt_d    = '0;
                rx_par_ok_d = (rx_s == ^rx_shift_q);
                rx_state_d  = RX_STOP;
            end
`endif
            RX_STOP: if (rx_cnt_q == BIT_LAST) begin
                rx_cnt_d   = '0;
                rx_state_d = RX_IDLE;
                if (!rx_s) begin
                    ferr_d     = 1'b1;
                    rx_state_d = RX_WAIT_HIGH;
                end else if (!rx_par_good) begin
                    ferr_d = 1'b1;
                end else begin
                    a_d       = rx_shift_q;
                    a_valid_d = 1'b1;
                end
            end
            RX_WAIT_HIGH: begin
                rx_cnt_d = '0;
                if (rx_s) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_sync_q  <= 2'b11;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            a_q        <= '0;
            a_valid_q  <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef SERIAL_PARITY_EN
            rx_par_ok_q <= 1'b1;
`endif
        end else begin
            rx_sync_q  <= {rx_sync_q[0], i_rx_0};
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            a_q        <= a_d;
            a_valid_q  <= a_valid_d;
            ferr_q     <= ferr_d;
`ifdef SERIAL_PARITY_EN
            rx_par_ok_q <= rx_par_ok_d;
`endif
        end
    end
endmodule

// File: tb/tb_serial_link_top.sv
// Directed bench for serial_link_top with TX looped to RX; honours SERIAL_PARITY_EN.
module tb_serial_link_top;
    localparam int W   = 16;
    localparam int CPB = 16;
`ifdef SERIAL_PARITY_EN
    localparam int FRAME_BITS = W + 3;
`else
    localparam int FRAME_BITS = W + 2;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  i_a;
    logic          i_a_valid;
    logic          o_a_ready, o_tx_0, o_tx_busy;
    logic [3:0]    o_level;
    logic          i_rx_0;
    logic [W-1:0]  o_a;
    logic          o_a_valid, o_frame_err;
    logic          loop_en, rx_drv;

    int checks_total  = 0;
    int checks_passed = 0;
    int valid_cnt = 0;
    int ferr_cnt  = 0;
    logic [W-1:0] rx_q[$];
    longint cyc = 0;
    longint busy_fall_cyc = 0;
    logic busy_prev = 1'b0;

    serial_link_top #(.WIDTH_BYTE(8), .WORDS(8), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .i_a(i_a), .i_a_valid(i_a_valid), .o_a_ready(o_a_ready),
        .o_tx_0(o_tx_0), .o_tx_busy(o_tx_busy), .o_level(o_level), .i_rx_0(i_rx_0),
        .o_a(o_a), .o_a_valid(o_a_valid), .o_frame_err(o_frame_err)
    );

    always #5 clk = ~clk;
    assign i_rx_0 = loop_en ? o_tx_0 : rx_drv;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_a_valid) begin
            valid_cnt++;
            rx_q.push_back(o_a);
        end
        if (o_frame_err) ferr_cnt++;
        if (busy_prev && !o_tx_busy) busy_fall_cyc = cyc;
        busy_prev = o_tx_busy;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        valid_cnt = 0;
        ferr_cnt = 0;
        rx_q.delete();
        busy_fall_cyc = 0;
    endtask

    task automatic wait_valid(input int n, input int budget, input string name);
        for (int t = 0; t < budget && valid_cnt < n; t++) tick(1);
        checks_total++;
        if (valid_cnt < n) $display("FAIL %s_timeout: got %0d valid pulses expected %0d", name, valid_cnt, n);
        else checks_passed++;
    endtask

    task automatic send_frame(input logic [W-1:0] w, input logic stop_bit, input logic par_bit);
        rx_drv = 1'b0;
        tick(CPB);
        for (int i = 0; i < W; i++) begin
            rx_drv = w[i];
            tick(CPB);
        end
`ifdef SERIAL_PARITY_EN
        rx_drv = par_bit;
        tick(CPB);
`else
        if (par_bit) rx_drv = 1'b1;
`endif
        rx_drv = stop_bit;
        tick(CPB);
        rx_drv = 1'b1;
    endtask

    task automatic test_reset();
        int t;
        rst = 1'b0; i_a = '0; i_a_valid = 1'b0; loop_en = 1'b1; rx_drv = 1'b1;
        #22;
        checks_total++; if (o_tx_0 !== 1'b1)      $display("FAIL rst_tx: got %b expected 1", o_tx_0); else checks_passed++;
        checks_total++; if (o_tx_busy !== 1'b0)   $display("FAIL rst_busy: got %b expected 0", o_tx_busy); else checks_passed++;
        checks_total++; if (o_level !== 4'd0)     $display("FAIL rst_level: got %0d expected 0", o_level); else checks_passed++;
        checks_total++; if (o_a_ready !== 1'b1)   $display("FAIL rst_ready: got %b expected 1", o_a_ready); else checks_passed++;
        checks_total++; if (o_a !== 16'h0000)     $display("FAIL rst_a: got %h expected 0000", o_a); else checks_passed++;
        checks_total++; if (o_a_valid !== 1'b0)   $display("FAIL rst_valid: got %b expected 0", o_a_valid); else checks_passed++;
        checks_total++; if (o_frame_err !== 1'b0) $display("FAIL rst_ferr: got %b expected 0", o_frame_err); else checks_passed++;
        @(posedge clk); #1; rst = 1'b1;
        tick(4);
        // Two all-zero words so the line sits low in DATA and the FIFO still holds one.
        i_a = 16'h0000; i_a_valid = 1'b1;
        tick(2);
        i_a_valid = 1'b0;
        for (t = 0; t < 20 && o_tx_0 !== 1'b0; t++) tick(1);
        tick(CPB * 4 + 8);
        checks_total++; if (o_tx_0 !== 1'b0)  $display("FAIL mid_data_line: got %b expected 0", o_tx_0); else checks_passed++;
        checks_total++; if (o_level !== 4'd1) $display("FAIL mid_data_level: got %0d expected 1", o_level); else checks_passed++;
        #3 rst = 1'b0;
        #1;
        checks_total++; if (o_tx_0 !== 1'b1)    $display("FAIL abort_tx: got %b expected 1", o_tx_0); else checks_passed++;
        checks_total++; if (o_level !== 4'd0)   $display("FAIL abort_level: got %0d expected 0", o_level); else checks_passed++;
        checks_total++; if (o_tx_busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", o_tx_busy); else checks_passed++;
        tick(2);
        rst = 1'b1;
        clear_mon();
        tick(FRAME_BITS * CPB + 50);
        checks_total++; if (valid_cnt != 0) $display("FAIL abort_no_valid: got %0d pulses expected 0", valid_cnt); else checks_passed++;
        checks_total++; if (ferr_cnt != 0)  $display("FAIL abort_no_ferr: got %0d pulses expected 0", ferr_cnt); else checks_passed++;
        $display("test_reset done");
    endtask

    task automatic test_loopback();
        clear_mon();
        i_a = 16'hA55A; i_a_valid = 1'b1;
        tick(1);
        i_a_valid = 1'b0;
        checks_total++; if (o_level !== 4'd1) $display("FAIL lb_level_n: got %0d expected 1", o_level); else checks_passed++;
        tick(1);
        checks_total++; if (o_tx_0 !== 1'b1)    $display("FAIL lb_tx_n1: got %b expected 1", o_tx_0); else checks_passed++;
        checks_total++; if (o_tx_busy !== 1'b1) $display("FAIL lb_busy_n1: got %b expected 1", o_tx_busy); else checks_passed++;
        tick(1);
        checks_total++; if (o_tx_0 !== 1'b0)    $display("FAIL lb_tx_n2: got %b expected 0", o_tx_0); else checks_passed++;
        wait_valid(1, FRAME_BITS * CPB + 100, "lb");
        tick(100);
        checks_total++; if (valid_cnt != 1)     $display("FAIL lb_valid_count: got %0d expected 1", valid_cnt); else checks_passed++;
        checks_total++; if (o_a !== 16'hA55A)   $display("FAIL lb_data: got %h expected a55a", o_a); else checks_passed++;
        checks_total++; if (ferr_cnt != 0)      $display("FAIL lb_ferr: got %0d expected 0", ferr_cnt); else checks_passed++;
        $display("test_loopback: sent a55a received %h", o_a);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] words [10];
        int idx;
        int t;
        logic acc;
        logic full_seen;
        longint n_cyc;
        words = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h0F0F,
                  16'hF0F0, 16'h00FF, 16'hFF00, 16'h8001, 16'h7FFE};
        clear_mon();
        idx = 0; full_seen = 1'b0; n_cyc = 0;
        i_a_valid = 1'b1;
        for (t = 0; t < 2000 && idx < 10; t++) begin
            i_a = words[idx];
            acc = o_a_ready;
            tick(1);
            if (acc) begin
                if (idx == 0) n_cyc = cyc;
                idx++;
            end
            if (!full_seen && !o_a_ready) begin
                full_seen = 1'b1;
                checks_total++; if (idx != 9)         $display("FAIL b2b_accepted_at_full: got %0d expected 9", idx); else checks_passed++;
                checks_total++; if (o_level !== 4'd8) $display("FAIL b2b_level_full: got %0d expected 8", o_level); else checks_passed++;
            end
        end
        i_a_valid = 1'b0;
        checks_total++; if (full_seen !== 1'b1) $display("FAIL b2b_full_seen: got %b expected 1", full_seen); else checks_passed++;
        checks_total++; if (idx != 10)          $display("FAIL b2b_all_accepted: got %0d expected 10", idx); else checks_passed++;
        wait_valid(10, 10 * FRAME_BITS * CPB + 500, "b2b");
        tick(50);
        checks_total++; if (valid_cnt != 10) $display("FAIL b2b_valid_count: got %0d expected 10", valid_cnt); else checks_passed++;
        for (int k = 0; k < 10; k++) begin
            logic [W-1:0] got;
            got = (k < rx_q.size()) ? rx_q[k] : 16'hxxxx;
            checks_total++;
            if (got !== words[k]) $display("FAIL b2b_word%0d: got %h expected %h", k, got, words[k]);
            else checks_passed++;
            $display("b2b word %0d: received %h", k, got);
        end
        checks_total++; if (ferr_cnt != 0) $display("FAIL b2b_ferr: got %0d expected 0", ferr_cnt); else checks_passed++;
        // Busy must stay high from the first pop until the tenth stop bit ends.
        checks_total++;
        if (busy_fall_cyc - n_cyc != longint'(1 + 10 * FRAME_BITS * CPB))
            $display("FAIL b2b_no_gap: got %0d busy cycles expected %0d", busy_fall_cyc - n_cyc, 1 + 10 * FRAME_BITS * CPB);
        else checks_passed++;
    endtask

    task automatic test_frame_err();
        loop_en = 1'b0; rx_drv = 1'b1;
        tick(40);
        clear_mon();
        send_frame(16'hBEEF, 1'b0, ^16'hBEEF);
        tick(3 * CPB);
        checks_total++; if (ferr_cnt != 1)     $display("FAIL ferr_count: got %0d expected 1", ferr_cnt); else checks_passed++;
        checks_total++; if (valid_cnt != 0)    $display("FAIL ferr_valid: got %0d expected 0", valid_cnt); else checks_passed++;
        checks_total++; if (o_a !== 16'h7FFE)  $display("FAIL ferr_a_held: got %h expected 7ffe", o_a); else checks_passed++;
        send_frame(16'h1234, 1'b1, ^16'h1234);
        tick(3 * CPB);
        checks_total++; if (valid_cnt != 1)    $display("FAIL ferr_next_valid: got %0d expected 1", valid_cnt); else checks_passed++;
        checks_total++; if (o_a !== 16'h1234)  $display("FAIL ferr_next_data: got %h expected 1234", o_a); else checks_passed++;
        checks_total++; if (ferr_cnt != 1)     $display("FAIL ferr_next_ferr: got %0d expected 1", ferr_cnt); else checks_passed++;
        $display("test_frame_err: bad stop then received %h", o_a);
    endtask

    task automatic test_glitch();
        clear_mon();
        rx_drv = 1'b0;
        tick(3);
        rx_drv = 1'b1;
        tick(40);
        checks_total++; if (valid_cnt != 0) $display("FAIL glitch_valid: got %0d expected 0", valid_cnt); else checks_passed++;
        checks_total++; if (ferr_cnt != 0)  $display("FAIL glitch_ferr: got %0d expected 0", ferr_cnt); else checks_passed++;
        send_frame(16'h00FF, 1'b1, ^16'h00FF);
        tick(3 * CPB);
        checks_total++; if (valid_cnt != 1)   $display("FAIL glitch_recover_valid: got %0d expected 1", valid_cnt); else checks_passed++;
        checks_total++; if (o_a !== 16'h00FF) $display("FAIL glitch_recover_data: got %h expected 00ff", o_a); else checks_passed++;
        $display("test_glitch: after glitch received %h", o_a);
    endtask

`ifdef SERIAL_PARITY_EN
    task automatic test_parity();
        clear_mon();
        send_frame(16'h0001, 1'b1, 1'b0);
        tick(3 * CPB);
        checks_total++; if (ferr_cnt != 1)    $display("FAIL par_bad_ferr: got %0d expected 1", ferr_cnt); else checks_passed++;
        checks_total++; if (valid_cnt != 0)   $display("FAIL par_bad_valid: got %0d expected 0", valid_cnt); else checks_passed++;
        checks_total++; if (o_a !== 16'h00FF) $display("FAIL par_bad_held: got %h expected 00ff", o_a); else checks_passed++;
        send_frame(16'h0001, 1'b1, 1'b1);
        tick(3 * CPB);
        checks_total++; if (valid_cnt != 1)   $display("FAIL par_good_valid: got %0d expected 1", valid_cnt); else checks_passed++;
        checks_total++; if (o_a !== 16'h0001) $display("FAIL par_good_data: got %h expected 0001", o_a); else checks_passed++;
        $display("test_parity: received %h", o_a);
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_loopback();
        test_back_to_back();
        test_frame_err();
        test_glitch();
`ifdef SERIAL_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
